hamming_encode_s: RTL

HAMMING_ENCODE_S -- requirements
Module: hamming_encode_s

---
 rtl/hamming_pkg.sv | 29 ++
 rtl/hamming74_enc.sv | 22 ++
 rtl/hamming_encode_s.sv | 119 +++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared constants and types for the serial Hamming(7,4) encoder and its
// combinational parity generator.
package hamming_pkg;

  // Codeword and data widths.
  localparam int CW_LEN = 7;
  localparam int DATA_W = 4;

  // Parity bit positions inside h[6:0].
  localparam int P6_IDX = 6;
  localparam int P5_IDX = 5;
  localparam int P3_IDX = 3;

  // Data bit positions inside h[6:0] (d3, d2, d1, d0).
  localparam int D3_IDX = 4;
  localparam int D2_IDX = 2;
  localparam int D1_IDX = 1;
  localparam int D0_IDX = 0;

  // err_idx value that leaves the codeword untouched.
  localparam logic [2:0] NO_INJECT = 3'd7;

  // Serializer states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } enc_state_e;

endpackage

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) encoder: places the data nibble and the three
// even-parity bits at their codeword positions.
module hamming74_enc
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CW_LEN-1:0] code_o
);

  // Data bits go straight through; each parity covers three data bits.
  always_comb begin
    code_o         = '0;
    code_o[D3_IDX] = data_i[3];
    code_o[D2_IDX] = data_i[2];
    code_o[D1_IDX] = data_i[1];
    code_o[D0_IDX] = data_i[0];
    code_o[P6_IDX] = data_i[3] ^ data_i[2] ^ data_i[0];
    code_o[P5_IDX] = data_i[3] ^ data_i[1] ^ data_i[0];
    code_o[P3_IDX] = data_i[2] ^ data_i[1] ^ data_i[0];
  end

endmodule

// File: rtl/hamming_encode_s.sv
// Serial Hamming(7,4) transmitter with optional single-bit error injection.
// The codeword is sent MSB first, one bit per STROBE_DIV cycles, with a
// one-cycle strobe in the last cycle of each bit period.
module hamming_encode_s
  import hamming_pkg::*;
#(
  parameter int unsigned STROBE_DIV = 4
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_in,
  input  logic       start,
  input  logic       err_en,
  input  logic [2:0] err_idx,
  output logic       d_out,
  output logic       strobe_out,
  output logic       busy,
  output logic       done
);

  enc_state_e          state_q, state_d;
  logic [CW_LEN-1:0]   cw_q, cw_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0]          div_cnt_q, div_cnt_d;
  logic                d_out_q, d_out_d;
  logic                done_q, done_d;

  logic [CW_LEN-1:0]   code_raw;
  logic [CW_LEN-1:0]   inject_mask;
  logic [CW_LEN-1:0]   code_latch;
  logic                div_last;

  hamming74_enc u_enc (
    .data_i (d_in),
    .code_o (code_raw)
  );

  // One-hot flip mask; NO_INJECT (7) never matches any of positions 0..6.
  genvar gi;
  generate
    for (gi = 0; gi < CW_LEN; gi++) begin : g_inject
      assign inject_mask[gi] = err_en && (err_idx == 3'(gi));
    end
  endgenerate

  assign code_latch = code_raw ^ inject_mask;
  assign div_last   = (div_cnt_q == 4'(STROBE_DIV - 1));

  // State and datapath registers; reset returns everything to idle/zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cw_q      <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      d_out_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cw_q      <= cw_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      d_out_q   <= d_out_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: load on acceptance, advance one bit per strobe,
  // return to idle with a done pulse after the seventh strobe.
  always_comb begin
    state_d   = state_q;
    cw_d      = cw_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    d_out_d   = d_out_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        d_out_d = 1'b0;
        if (start) begin
          // First bit goes straight to the output register; the rest is
          // kept left-aligned so the next bit is always cw_q[6].
          state_d   = ST_SHIFT;
          d_out_d   = code_latch[CW_LEN-1];
          cw_d      = {code_latch[CW_LEN-2:0], 1'b0};
          bit_cnt_d = 3'd6;
          div_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (bit_cnt_q == 3'd0) begin
            state_d = ST_IDLE;
            d_out_d = 1'b0;
            cw_d    = '0;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            d_out_d   = cw_q[CW_LEN-1];
            cw_d      = {cw_q[CW_LEN-2:0], 1'b0};
          end
        end else begin
          div_cnt_d = div_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign d_out      = d_out_q;
  assign strobe_out = (state_q == ST_SHIFT) && div_last;
  assign busy       = (state_q == ST_SHIFT);
  assign done       = done_q;

endmodule
